npu_ahb_img_loader: RTL and testbench

AHB-Lite master that loads one image frame into the NPU slave port and retrieves the classification result. It accepts RGB bytes from a valid/ready pixel stream and writes each byte into the NPU RGB input memory. After each completed row it writes the row-done control register. After the last row it polls the status register until the NPU reports done, then presents the predicted class. It sits between the camera/pixel front end and the NPU AHB slave, acting as the sole master on that bus segment.

---
 rtl/npu_ahb_img_loader.sv | 211 +++++++++++++++++++++
 tb/tb_npu_ahb_img_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_ahb_img_loader.sv
// npu_ahb_img_loader: AHB-Lite master that streams one RGB frame into the NPU,
// signals each finished row, then polls status until a class is available.
module npu_ahb_img_loader #(
  parameter logic [31:0] RGB_BASE      = 32'h0000_0000,
  parameter logic [31:0] ROW_CTRL_ADDR = 32'h0000_2000,
  parameter logic [31:0] STATUS_ADDR   = 32'h0000_2004,
  parameter int          ROW_BYTES     = 96,
  parameter int          NUM_ROWS      = 32,
  parameter int          POLL_GAP      = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        pix_valid_i,
  input  logic [7:0]  pix_data_i,
  output logic        pix_ready_o,
  output logic [31:0] haddr_o,
  output logic        hwrite_o,
  output logic [2:0]  hsize_o,
  output logic [2:0]  hburst_o,
  output logic [3:0]  hprot_o,
  output logic [1:0]  htrans_o,
  output logic        hmastlock_o,
  output logic [31:0] hwdata_o,
  input  logic        hready_i,
  input  logic        hresp_i,
  input  logic [31:0] hrdata_i,
  output logic        busy_o,
  output logic [4:0]  class_o,
  output logic        class_valid_o,
  output logic        err_o
);
  localparam int BCW = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
  localparam int RCW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(ROW_BYTES - 1);
  localparam logic [RCW-1:0] LAST_ROW  = RCW'(NUM_ROWS - 1);
  localparam logic [GCW-1:0] LAST_GAP  = GCW'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PIX_WAIT, S_WR_ADDR, S_WR_DATA, S_ROW_ADDR, S_ROW_DATA,
    S_POLL_ADDR, S_POLL_DATA, S_POLL_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      pix_byte_q, pix_byte_d;
  logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [RCW-1:0]  row_cnt_q, row_cnt_d;
  logic [11:0]     offset_q, offset_d;
  logic [GCW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0]     haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic            hwrite_q, hwrite_d;
  logic [2:0]      hsize_q, hsize_d;
  logic [1:0]      htrans_q, htrans_d;
  logic            pix_ready_q, pix_ready_d, busy_q, busy_d;
  logic [4:0]      class_q, class_d;
  logic            class_valid_q, class_valid_d, err_q, err_d;
  logic            data_ok;

  // Only the done bit and class field of the status word are meaningful.
  logic unused_rdata;
  assign unused_rdata = ^hrdata_i[31:6];

  // A data phase retires cleanly only on a ready beat without an error.
  assign data_ok = hready_i && !hresp_i;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: one transfer at a time, every data phase can abort on hresp.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (start_i) state_d = S_PIX_WAIT;
      S_PIX_WAIT:  if (pix_valid_i) state_d = S_WR_ADDR;
      S_WR_ADDR:   if (hready_i) state_d = S_WR_DATA;
      S_WR_DATA:   if (hresp_i) state_d = S_IDLE;
                   else if (hready_i) state_d = (byte_cnt_q == LAST_BYTE) ? S_ROW_ADDR : S_PIX_WAIT;
      S_ROW_ADDR:  if (hready_i) state_d = S_ROW_DATA;
      S_ROW_DATA:  if (hresp_i) state_d = S_IDLE;
                   else if (hready_i) state_d = (row_cnt_q == LAST_ROW) ? S_POLL_ADDR : S_PIX_WAIT;
      S_POLL_ADDR: if (hready_i) state_d = S_POLL_DATA;
      S_POLL_DATA: if (hresp_i) state_d = S_IDLE;
                   else if (hready_i) state_d = hrdata_i[0] ? S_IDLE : S_POLL_WAIT;
      S_POLL_WAIT: if (gap_cnt_q == LAST_GAP) state_d = S_POLL_ADDR;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the bus sees them one edge
  // after the decision; counters and status update on retiring data phases.
  always_comb begin
    pix_byte_d    = pix_byte_q;
    byte_cnt_d    = byte_cnt_q;
    row_cnt_d     = row_cnt_q;
    offset_d      = offset_q;
    gap_cnt_d     = '0;
    haddr_d       = haddr_q;
    hwdata_d      = hwdata_q;
    hwrite_d      = hwrite_q;
    hsize_d       = hsize_q;
    err_d         = err_q;
    class_d       = class_q;
    class_valid_d = 1'b0;
    htrans_d      = 2'b00;
    pix_ready_d   = (state_d == S_PIX_WAIT);
    busy_d        = (state_d != S_IDLE);

    unique case (state_q)
      S_IDLE: if (start_i) begin
        err_d      = 1'b0;
        byte_cnt_d = '0;
        row_cnt_d  = '0;
        offset_d   = '0;
      end
      S_PIX_WAIT: if (pix_valid_i) pix_byte_d = pix_data_i;
      S_WR_DATA: if (data_ok) begin
        offset_d   = offset_q + 12'd1;
        byte_cnt_d = (byte_cnt_q == LAST_BYTE) ? '0 : byte_cnt_q + 1'b1;
      end
      S_ROW_DATA: if (data_ok) row_cnt_d = row_cnt_q + 1'b1;
      S_POLL_DATA: if (data_ok && hrdata_i[0]) begin
        class_d       = hrdata_i[5:1];
        class_valid_d = 1'b1;
      end
      S_POLL_WAIT: gap_cnt_d = gap_cnt_q + 1'b1;
      default: ;
    endcase

    if ((state_q == S_WR_DATA || state_q == S_ROW_DATA || state_q == S_POLL_DATA) && hresp_i)
      err_d = 1'b1;

    unique case (state_d)
      S_WR_ADDR: begin
        htrans_d = 2'b10;
        haddr_d  = RGB_BASE + {20'd0, offset_q};
        hwrite_d = 1'b1;
        hsize_d  = 3'b000;
      end
      S_ROW_ADDR: begin
        htrans_d = 2'b10;
        haddr_d  = ROW_CTRL_ADDR;
        hwrite_d = 1'b1;
        hsize_d  = 3'b010;
      end
      S_POLL_ADDR: begin
        htrans_d = 2'b10;
        haddr_d  = STATUS_ADDR;
        hwrite_d = 1'b0;
        hsize_d  = 3'b010;
      end
      S_WR_DATA:  hwdata_d = {4{pix_byte_q}};
      S_ROW_DATA: hwdata_d = 32'h1;
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_byte_q    <= '0;
      byte_cnt_q    <= '0;
      row_cnt_q     <= '0;
      offset_q      <= '0;
      gap_cnt_q     <= '0;
      haddr_q       <= '0;
      hwdata_q      <= '0;
      hwrite_q      <= 1'b0;
      hsize_q       <= '0;
      htrans_q      <= '0;
      pix_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      class_q       <= '0;
      class_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      pix_byte_q    <= pix_byte_d;
      byte_cnt_q    <= byte_cnt_d;
      row_cnt_q     <= row_cnt_d;
      offset_q      <= offset_d;
      gap_cnt_q     <= gap_cnt_d;
      haddr_q       <= haddr_d;
      hwdata_q      <= hwdata_d;
      hwrite_q      <= hwrite_d;
      hsize_q       <= hsize_d;
      htrans_q      <= htrans_d;
      pix_ready_q   <= pix_ready_d;
      busy_q        <= busy_d;
      class_q       <= class_d;
      class_valid_q <= class_valid_d;
      err_q         <= err_d;
    end
  end

  assign haddr_o       = haddr_q;
  assign hwdata_o      = hwdata_q;
  assign hwrite_o      = hwrite_q;
  assign hsize_o       = hsize_q;
  assign htrans_o      = htrans_q;
  assign pix_ready_o   = pix_ready_q;
  assign busy_o        = busy_q;
  assign class_o       = class_q;
  assign class_valid_o = class_valid_q;
  assign err_o         = err_q;
  assign hburst_o      = 3'b000;
  assign hprot_o       = 4'b0011;
  assign hmastlock_o   = 1'b0;
endmodule

// File: tb/tb_npu_ahb_img_loader.sv
// Bench for npu_ahb_img_loader: random pixel source, AHB slave with wait-state
// and error injection, and a frame-level reference of the expected transfer list.
module tb_npu_ahb_img_loader;
  localparam int          RB = 4, NR = 2, PG = 3;
  localparam logic [31:0] RGB = 32'h0, ROWC = 32'h2000, STAT = 32'h2004;

  logic clk = 1'b0, resetn = 1'b0;
  logic start_drv = 1'b0, start_mon = 1'b0;
  logic pix_valid_i = 1'b0, pix_ready_o;
  logic [7:0] pix_data_i = '0;
  logic [31:0] haddr_o, hwdata_o, hrdata_i = '0;
  logic hwrite_o, hmastlock_o, hready_i = 1'b1, hresp_i = 1'b0;
  logic [2:0] hsize_o, hburst_o;
  logic [3:0] hprot_o;
  logic [1:0] htrans_o;
  logic busy_o, class_valid_o, err_o;
  logic [4:0] class_o;

  npu_ahb_img_loader #(.RGB_BASE(RGB), .ROW_CTRL_ADDR(ROWC), .STATUS_ADDR(STAT),
    .ROW_BYTES(RB), .NUM_ROWS(NR), .POLL_GAP(PG)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_drv | start_mon),
    .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i), .pix_ready_o(pix_ready_o),
    .haddr_o(haddr_o), .hwrite_o(hwrite_o), .hsize_o(hsize_o), .hburst_o(hburst_o),
    .hprot_o(hprot_o), .htrans_o(htrans_o), .hmastlock_o(hmastlock_o),
    .hwdata_o(hwdata_o), .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i),
    .busy_o(busy_o), .class_o(class_o), .class_valid_o(class_valid_o), .err_o(err_o));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic wr; logic [2:0] size; logic [31:0] data; } xfer_t;

  int n_cmp = 0, n_bad = 0;
  xfer_t got_q[$], exp_q[$];
  logic [7:0] frame_bytes[$];
  logic [31:0] stat_vals[$];
  int hs_cyc[$], rd_cyc[$];
  logic [4:0] exp_class;
  // bench-side knobs written by the stimulus process only
  int wait_pol = 0, err_abs = -1, rd_base = 0, gb = 0, hb = 0, rb = 0, cb = 0;
  logic so_done = 1'b0;
  // slave/monitor-owned state
  int cyc = 0, wl = 0, wr_cnt = 0, stat_cnt = 0, cv_cnt = 0;
  logic dp_act = 1'b0, dp_wr = 1'b0, newph = 1'b1, hs_pend = 1'b0;
  logic [31:0] dp_addr = '0, dp_wd = '0, ap_addr = '0;
  logic [2:0] dp_size = '0;
  logic [3:0] ap_ctl = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick_wait();
    if (wait_pol == 1) return 3;
    if (wait_pol == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  function automatic logic [31:0] cur_status();
    int k;
    k = stat_cnt - rd_base;
    if (k >= 0 && k < stat_vals.size()) return stat_vals[k];
    return 32'h1;
  endfunction

  // Slave + protocol monitor, evaluated mid-cycle on stable DUT outputs; it
  // decides hready/hresp/hrdata for the edge that follows.
  always @(negedge clk) begin
    #1;
    cyc++;
    start_mon = 1'b0;
    hresp_i   = 1'b0;
    if (!resetn) begin
      dp_act = 1'b0; newph = 1'b1; wl = 0; hs_pend = 1'b0; hready_i = 1'b1;
    end else begin
      if (class_valid_o) cv_cnt++;
      if (hs_pend) begin
        chk("hs_to_addr_phase", {htrans_o, hwrite_o, hsize_o}, {2'b10, 1'b1, 3'b000});
        hs_pend = 1'b0;
      end
      if (pix_valid_i && pix_ready_o) begin hs_pend = 1'b1; hs_cyc.push_back(cyc); end
      if (pix_ready_o) chk("ready_only_pix_wait", {busy_o, dp_act, htrans_o}, 4'b1000);
      if (dp_act) chk("no_pipelined_addr", htrans_o, 2'b00);
      if (dp_act || htrans_o == 2'b10) begin
        if (newph) begin
          wl = pick_wait(); newph = 1'b0;
          if (dp_act) dp_wd = hwdata_o;
          else begin ap_addr = haddr_o; ap_ctl = {hwrite_o, hsize_o}; end
        end else if (dp_act) begin
          if (dp_wr) chk("hwdata_hold", hwdata_o, dp_wd);
        end else chk("addr_hold", {haddr_o, hwrite_o, hsize_o}, {ap_addr, ap_ctl});
        if (wl > 0) begin hready_i = 1'b0; wl--; end
        else hready_i = 1'b1;
      end else hready_i = 1'b1;

      if (dp_act) begin
        hrdata_i = cur_status();
        if (hready_i) begin
          if (dp_wr && dp_size == 3'b000 && wr_cnt == err_abs) begin
            hresp_i = 1'b1;
            wr_cnt++;
          end else begin
            got_q.push_back('{dp_addr, dp_wr, dp_size, dp_wr ? hwdata_o : hrdata_i});
            if (dp_wr && dp_size == 3'b000) wr_cnt++;
            if (!dp_wr) begin
              stat_cnt++;
              if (hrdata_i[0] && so_done) start_mon = 1'b1;
            end
          end
          dp_act = 1'b0; newph = 1'b1;
        end
      end else if (htrans_o == 2'b10 && hready_i) begin
        dp_act = 1'b1; dp_addr = haddr_o; dp_wr = hwrite_o; dp_size = hsize_o; newph = 1'b1;
        if (!hwrite_o) rd_cyc.push_back(cyc);
      end
    end
  end

  // Frame-level reference: every byte to its linear address with the byte
  // replicated, a row-done write after each row, then one read per status word
  // until the done bit appears. An error beat truncates the list.
  function automatic void build_expected(input int eidx);
    xfer_t t;
    int idx;
    exp_q.delete();
    exp_class = '0;
    for (int r = 0; r < NR; r++) begin
      for (int b = 0; b < RB; b++) begin
        idx = r * RB + b;
        if (idx == eidx) return;
        t = '{RGB + 32'(idx), 1'b1, 3'b000, {4{frame_bytes[idx]}}};
        exp_q.push_back(t);
      end
      t = '{ROWC, 1'b1, 3'b010, 32'h1};
      exp_q.push_back(t);
    end
    foreach (stat_vals[k]) begin
      t = '{STAT, 1'b0, 3'b010, stat_vals[k]};
      exp_q.push_back(t);
      if (stat_vals[k][0]) begin exp_class = stat_vals[k][5:1]; break; end
    end
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_outs"}, {haddr_o, hwdata_o, hwrite_o, hsize_o, htrans_o, pix_ready_o,
                         busy_o, class_o, class_valid_o, err_o}, '0);
    chk({tag, "_const"}, {hburst_o, hprot_o, hmastlock_o}, {3'b000, 4'b0011, 1'b0});
  endtask

  task automatic fill_rand();
    frame_bytes.delete();
    for (int i = 0; i < RB * NR; i++) frame_bytes.push_back(8'($urandom));
  endtask

  task automatic run_frame(input int gapmax, input int mid_at, input int eidx);
    int bound, n;
    build_expected(eidx);
    gb = got_q.size(); hb = hs_cyc.size(); rb = rd_cyc.size(); cb = cv_cnt;
    rd_base = stat_cnt;
    err_abs = (eidx >= 0) ? wr_cnt + eidx : -1;
    @(negedge clk); start_drv = 1'b1;
    @(negedge clk); start_drv = 1'b0;
    chk("start_busy", busy_o, 1'b1);
    chk("start_clears_err", err_o, 1'b0);
    for (int i = 0; i < frame_bytes.size(); i++) begin
      if (err_o) break;
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
      if (i == mid_at) start_drv = 1'b1;
      pix_valid_i = 1'b1; pix_data_i = frame_bytes[i];
      bound = 0;
      while (!pix_ready_o && !err_o && bound < 200) begin
        @(negedge clk); start_drv = 1'b0; bound++;
      end
      if (bound >= 200) chk("pix_accept_timeout", 0, 1);
      if (err_o) begin pix_valid_i = 1'b0; start_drv = 1'b0; break; end
      @(negedge clk); start_drv = 1'b0; pix_valid_i = 1'b0;
    end
    bound = 0;
    while (busy_o && bound < 2000) begin @(negedge clk); bound++; end
    if (bound >= 2000) chk("frame_timeout", 0, 1);
    repeat (4) @(negedge clk);
    chk("idle_after_frame", busy_o, 1'b0);
    n = got_q.size() - gb;
    chk("xfer_count", n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk($sformatf("xfer%0d", i),
          {got_q[gb+i].addr, got_q[gb+i].wr, got_q[gb+i].size, got_q[gb+i].data},
          {exp_q[i].addr, exp_q[i].wr, exp_q[i].size, exp_q[i].data});
    if (eidx < 0) begin
      chk("class_valid_pulses", cv_cnt - cb, 1);
      chk("class_value", class_o, exp_class);
      chk("err_clear", err_o, 1'b0);
    end else begin
      chk("class_valid_none", cv_cnt - cb, 0);
      chk("err_set", err_o, 1'b1);
    end
  endtask

  initial begin
    int bound, n;
    #3 check_reset_vals("reset");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // basic frame, zero wait, back-to-back pixels
    frame_bytes.delete();
    for (int i = 0; i < RB * NR; i++) frame_bytes.push_back(8'h10 + 8'(i));
    stat_vals = '{32'h0000_0015};
    run_frame(0, -1, -1);
    chk("basic_class", class_o, 5'd10);
    if (hs_cyc.size() >= hb + 3) begin
      chk("throughput_0_1", hs_cyc[hb+1] - hs_cyc[hb], 3);
      chk("throughput_1_2", hs_cyc[hb+2] - hs_cyc[hb+1], 3);
    end else chk("handshakes_seen", hs_cyc.size() - hb, 3);

    // fixed three wait states in every phase
    wait_pol = 1; fill_rand();
    stat_vals = '{$urandom | 32'h1};
    run_frame(0, -1, -1);

    // polling with gap, start pulsed on the final status edge is ignored
    wait_pol = 0; so_done = 1'b1; fill_rand();
    stat_vals = '{32'h0, 32'h0, 32'h3F};
    run_frame(2, -1, -1);
    so_done = 1'b0;
    chk("poll_class", class_o, 5'd31);
    if (rd_cyc.size() >= rb + 3) begin
      chk("poll_gap_1", rd_cyc[rb+1] - rd_cyc[rb], PG + 2);
      chk("poll_gap_2", rd_cyc[rb+2] - rd_cyc[rb+1], PG + 2);
    end else chk("poll_reads_seen", rd_cyc.size() - rb, 3);

    // bus error on third byte write, then bus stays quiet
    fill_rand(); stat_vals = '{32'h1};
    run_frame(0, -1, 2);
    n = got_q.size();
    repeat (20) @(negedge clk);
    chk("err_no_more_xfers", got_q.size(), n);
    chk("err_bus_idle", {htrans_o, busy_o, err_o}, {2'b00, 1'b0, 1'b1});

    // random gaps, random wait states, mid-frame start, random poll lengths
    wait_pol = 2;
    for (int it = 0; it < 3; it++) begin
      fill_rand();
      stat_vals.delete();
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n - 1; k++) stat_vals.push_back($urandom & ~32'h1);
      stat_vals.push_back($urandom | 32'h1);
      run_frame(4, int'($urandom_range(1, RB * NR - 1)), -1);
    end

    // reset asserted during a byte data phase
    wait_pol = 1;
    @(negedge clk); start_drv = 1'b1;
    @(negedge clk); start_drv = 1'b0;
    pix_valid_i = 1'b1; pix_data_i = 8'hAB;
    bound = 0;
    forever begin
      @(negedge clk); #2;
      if ((dp_act && dp_wr && htrans_o == 2'b00) || bound > 100) break;
      bound++;
    end
    if (bound > 100) chk("reach_wr_data", 0, 1);
    resetn = 1'b0;
    #1 check_reset_vals("reset_mid_frame");
    pix_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_reset_vals("reset_release");

    // fresh frame after reset restarts at address 0
    wait_pol = 0; fill_rand();
    stat_vals = '{32'h0000_0009};
    run_frame(1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
